// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd256;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction and a data requester onto one memory port.
// D has fixed priority; every grant is bounded by a timeout that raises BusError.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InstrMemReadEnable,
    input  logic [31:0] PCForInstrMem,
    output logic        InstrMemAck,
    output logic [31:0] Instruction,
    input  logic        DataMemReadEnable,
    input  logic        DataMemWriteEnable,
    input  logic [31:0] DataMemAddress,
    input  logic [31:0] WriteData,
    input  logic [3:0]  DataMemByteEnable,
    output logic        DataMemAck,
    output logic [31:0] ReadDataOriginal,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic [3:0]  MemByteEnable,
    output logic        MemReadEnable,
    output logic        MemWriteEnable,
    input  logic        MemAck,
    input  logic [31:0] MemReadData,
    output logic        BusError
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic             mask_i_q, mask_i_d;
    logic             mask_d_q, mask_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    logic             i_req_s, d_req_s, timeout_s;
    logic             ack_i_s, ack_d_s;
    logic [31:0]      rdata_i_s, rdata_d_s;

    assign i_req_s   = InstrMemReadEnable & ~mask_i_q;
    assign d_req_s   = (DataMemReadEnable | DataMemWriteEnable) & ~mask_d_q;
    assign timeout_s = (cnt_q == CNT_MAX);

    // Next-state, grant latching, completion and timeout decisions.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        mask_i_d  = 1'b0;
        mask_d_d  = 1'b0;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        ack_i_s   = 1'b0;
        ack_d_s   = 1'b0;
        rdata_i_s = 32'h0;
        rdata_d_s = 32'h0;

        case (state_q)
            IDLE: begin
                if (d_req_s) begin
                    state_d = SERVE_D;
                    addr_d  = DataMemAddress;
                    wdata_d = WriteData;
                    be_d    = DataMemByteEnable;
                    rd_en_d = DataMemReadEnable;
                    wr_en_d = DataMemWriteEnable;
                    cnt_d   = '0;
                end else if (i_req_s) begin
                    state_d = SERVE_I;
                    addr_d  = PCForInstrMem;
                    wdata_d = 32'h0;
                    be_d    = 4'b1111;
                    rd_en_d = 1'b1;
                    wr_en_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I: begin
                // A real MemAck takes precedence over a coincident timeout.
                if (MemAck || timeout_s) begin
                    ack_i_s   = 1'b1;
                    rdata_i_s = MemAck ? MemReadData : 32'h0;
                    bus_err_d = bus_err_q | ~MemAck;
                    state_d   = IDLE;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    mask_i_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SERVE_D: begin
                if (MemAck || timeout_s) begin
                    ack_d_s   = 1'b1;
                    rdata_d_s = MemAck ? MemReadData : 32'h0;
                    bus_err_d = bus_err_q | ~MemAck;
                    state_d   = IDLE;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    mask_d_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    // State, latched request and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            mask_i_q  <= 1'b0;
            mask_d_q  <= 1'b0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            mask_i_q  <= mask_i_d;
            mask_d_q  <= mask_d_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign MemAddress       = addr_q;
    assign MemWriteData     = wdata_q;
    assign MemByteEnable    = be_q;
    assign MemReadEnable    = rd_en_q;
    assign MemWriteEnable   = wr_en_q;
    assign BusError         = bus_err_q;
    assign InstrMemAck      = ack_i_s & ~RST;
    assign DataMemAck       = ack_d_s & ~RST;
    assign Instruction      = RST ? 32'h0 : rdata_i_s;
    assign ReadDataOriginal = RST ? 32'h0 : rdata_d_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks are queued as stimulus is driven.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        InstrMemReadEnable;
    logic [31:0] PCForInstrMem;
    logic        InstrMemAck;
    logic [31:0] Instruction;
    logic        DataMemReadEnable;
    logic        DataMemWriteEnable;
    logic [31:0] DataMemAddress;
    logic [31:0] WriteData;
    logic [3:0]  DataMemByteEnable;
    logic        DataMemAck;
    logic [31:0] ReadDataOriginal;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [3:0]  MemByteEnable;
    logic        MemReadEnable;
    logic        MemWriteEnable;
    logic        MemAck;
    logic [31:0] MemReadData;
    logic        BusError;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_got;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .InstrMemReadEnable(InstrMemReadEnable), .PCForInstrMem(PCForInstrMem),
        .InstrMemAck(InstrMemAck), .Instruction(Instruction),
        .DataMemReadEnable(DataMemReadEnable), .DataMemWriteEnable(DataMemWriteEnable),
        .DataMemAddress(DataMemAddress), .WriteData(WriteData),
        .DataMemByteEnable(DataMemByteEnable),
        .DataMemAck(DataMemAck), .ReadDataOriginal(ReadDataOriginal),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemByteEnable(MemByteEnable), .MemReadEnable(MemReadEnable),
        .MemWriteEnable(MemWriteEnable), .MemAck(MemAck),
        .MemReadData(MemReadData), .BusError(BusError)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every requester ack must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!RST && (InstrMemAck || DataMemAck)) begin
            mon_got.is_d = DataMemAck;
            mon_got.data = DataMemAck ? ReadDataOriginal : Instruction;
            checks++;
            if (InstrMemAck && DataMemAck) begin
                errors++;
                $display("FAIL sb_both_acks: got I=%b D=%b, required only one", InstrMemAck, DataMemAck);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got is_d=%b data=%h, required no ack", mon_got.is_d, mon_got.data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_got !== mon_e) begin
                    errors++;
                    $display("FAIL sb_ack: got is_d=%b data=%h, required is_d=%b data=%h",
                             mon_got.is_d, mon_got.data, mon_e.is_d, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        InstrMemReadEnable = 1'b0; PCForInstrMem = 32'h0;
        DataMemReadEnable = 1'b0; DataMemWriteEnable = 1'b0;
        DataMemAddress = 32'h0; WriteData = 32'h0; DataMemByteEnable = 4'h0;
        MemAck = 1'b0; MemReadData = 32'h0;
        tick(); tick();
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, MemAddress, MemWriteData, MemByteEnable} !== 70'h0) begin
            errors++;
            $display("FAIL reset_mem_port: got re=%b we=%b a=%h wd=%h be=%h, required all 0",
                     MemReadEnable, MemWriteEnable, MemAddress, MemWriteData, MemByteEnable);
        end
        checks++;
        if ({InstrMemAck, DataMemAck, BusError} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got ia=%b da=%b be=%b, required 000", InstrMemAck, DataMemAck, BusError);
        end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_i_read();
        tick();
        InstrMemReadEnable = 1'b1; PCForInstrMem = 32'h40;
        @(negedge CLK);
        checks++;
        if (MemReadEnable !== 1'b0) begin
            errors++; $display("FAIL i_not_early: got re=%b, required 0", MemReadEnable);
        end
        tick();
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData} !== {1'b1, 1'b0, 32'h40, 4'hF, 32'h0}) begin
            errors++;
            $display("FAIL i_grant: got re=%b we=%b a=%h be=%h wd=%h, required 1 0 40 f 0",
                     MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData);
        end
        tick(); tick();
        tick();
        MemAck = 1'b1; MemReadData = 32'h8C010004;
        exp_q.push_back({1'b0, 32'h8C010004});
        @(negedge CLK);
        checks++;
        if ({InstrMemAck, Instruction} !== {1'b1, 32'h8C010004}) begin
            errors++; $display("FAIL i_ack: got ack=%b data=%h, required 1 8c010004", InstrMemAck, Instruction);
        end
        tick();
        MemAck = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable} !== 2'b00) begin
            errors++; $display("FAIL i_mask_cycle: got re=%b we=%b, required 00", MemReadEnable, MemWriteEnable);
        end
        tick();
        InstrMemReadEnable = 1'b0;
        @(negedge CLK);
        checks++;
        if (MemReadEnable !== 1'b0) begin
            errors++; $display("FAIL i_no_reaccess: got re=%b, required 0", MemReadEnable);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        InstrMemReadEnable = 1'b1; PCForInstrMem = 32'h100;
        DataMemWriteEnable = 1'b1; DataMemAddress = 32'h2000;
        WriteData = 32'hDEADBEEF; DataMemByteEnable = 4'b0011;
        tick();
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData} !== {1'b0, 1'b1, 32'h2000, 4'b0011, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sim_d_first: got re=%b we=%b a=%h be=%h wd=%h, required 0 1 2000 3 deadbeef",
                     MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData);
        end
        tick();
        MemAck = 1'b1; MemReadData = 32'h11112222;
        exp_q.push_back({1'b1, 32'h11112222});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
        tick();
        DataMemWriteEnable = 1'b0;
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData} !== {1'b1, 1'b0, 32'h100, 4'hF, 32'h0}) begin
            errors++;
            $display("FAIL sim_i_second: got re=%b we=%b a=%h be=%h wd=%h, required 1 0 100 f 0",
                     MemReadEnable, MemWriteEnable, MemAddress, MemByteEnable, MemWriteData);
        end
        tick();
        MemAck = 1'b1; MemReadData = 32'hCAFE0001;
        exp_q.push_back({1'b0, 32'hCAFE0001});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0; InstrMemReadEnable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        tick();
        DataMemReadEnable = 1'b1; DataMemAddress = 32'h3000;
        tick();
        InstrMemReadEnable = 1'b1; PCForInstrMem = 32'h200;
        tick();
        MemAck = 1'b1; MemReadData = 32'h0000A5A5;
        exp_q.push_back({1'b1, 32'h0000A5A5});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
        tick();
        DataMemAddress = 32'h3004;
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, MemAddress} !== {1'b1, 1'b0, 32'h200}) begin
            errors++;
            $display("FAIL b2b_i_in_mask: got re=%b we=%b a=%h, required 1 0 200", MemReadEnable, MemWriteEnable, MemAddress);
        end
        // The I requester withdraws mid-access; the access must still complete.
        InstrMemReadEnable = 1'b0;
        tick();
        MemAck = 1'b1; MemReadData = 32'h00005A5A;
        exp_q.push_back({1'b0, 32'h00005A5A});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemAddress} !== {1'b1, 32'h3004}) begin
            errors++; $display("FAIL b2b_d_after: got re=%b a=%h, required 1 3004", MemReadEnable, MemAddress);
        end
        tick();
        MemAck = 1'b1; MemReadData = 32'h00000077;
        exp_q.push_back({1'b1, 32'h00000077});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0; DataMemReadEnable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int  n;
        logic got;
        tick();
        DataMemReadEnable = 1'b1; DataMemAddress = 32'h4000;
        MemReadData = 32'hFFFFFFFF;
        exp_q.push_back({1'b1, 32'h0});
        @(negedge CLK);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            @(negedge CLK);
            if (DataMemAck === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != TO + 1) begin
            errors++; $display("FAIL to_ack_cycle: got ack=%b at serve cycle %0d, required 1 at %0d", got, n, TO + 1);
        end
        tick();
        DataMemReadEnable = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
        checks++;
        if ({BusError, MemReadEnable} !== 2'b10) begin
            errors++; $display("FAIL to_buserr: got be=%b re=%b, required 1 0", BusError, MemReadEnable);
        end
        tick();
        InstrMemReadEnable = 1'b1; PCForInstrMem = 32'h500;
        tick();
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemAddress} !== {1'b1, 32'h500}) begin
            errors++; $display("FAIL to_next_grant: got re=%b a=%h, required 1 500", MemReadEnable, MemAddress);
        end
        tick();
        MemAck = 1'b1; MemReadData = 32'h00000500;
        exp_q.push_back({1'b0, 32'h00000500});
        @(negedge CLK);
        tick();
        MemAck = 1'b0; MemReadData = 32'h0; InstrMemReadEnable = 1'b0;
        @(negedge CLK);
        checks++;
        if (BusError !== 1'b1) begin
            errors++; $display("FAIL to_sticky: got be=%b, required 1", BusError);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        InstrMemReadEnable = 1'b1; PCForInstrMem = 32'h600;
        tick();
        @(negedge CLK);
        checks++;
        if (MemReadEnable !== 1'b1) begin
            errors++; $display("FAIL rst_pre_grant: got re=%b, required 1", MemReadEnable);
        end
        tick();
        RST = 1'b1; InstrMemReadEnable = 1'b0;
        MemAck = 1'b1; MemReadData = 32'h12345678;
        @(negedge CLK);
        checks++;
        if ({InstrMemAck, DataMemAck} !== 2'b00) begin
            errors++; $display("FAIL rst_no_ack: got ia=%b da=%b, required 00", InstrMemAck, DataMemAck);
        end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({MemReadEnable, MemWriteEnable, InstrMemAck, DataMemAck, BusError} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_after: got re=%b we=%b ia=%b da=%b be=%b, required 00000",
                     MemReadEnable, MemWriteEnable, InstrMemAck, DataMemAck, BusError);
        end
        tick();
        MemAck = 1'b0; MemReadData = 32'h0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending acks, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum cycles a grant waits for MemAck before it is aborted (legal range 2..65535).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port InstrMemReadEnable  input  1  I-requester read request, held high until acked.
REQ-005 SHALL have port PCForInstrMem  input  32  I-requester word address.
REQ-006 SHALL have port InstrMemAck  output  1  one-cycle completion pulse to I-requester.
REQ-007 SHALL have port Instruction  output  32  I-requester read data, valid only while InstrMemAck=1.
REQ-008 SHALL have ports DataMemReadEnable, DataMemWriteEnable  input  1 each  D-requester read and write requests, held high until acked.
REQ-009 SHALL have ports DataMemAddress  input  32, WriteData  input  32, DataMemByteEnable  input  4  D-requester address, write data and byte lanes.
REQ-010 SHALL have ports DataMemAck  output  1, ReadDataOriginal  output  32  D completion pulse and read data, data valid only with the ack.
REQ-011 SHALL have ports MemAddress  output  32, MemWriteData  output  32, MemByteEnable  output  4, MemReadEnable  output  1, MemWriteEnable  output  1  shared memory port.
REQ-012 SHALL have ports MemAck  input  1  one-cycle memory completion pulse, and MemReadData  input  32  memory read data, valid with MemAck.
REQ-013 SHALL have port BusError  output  1  sticky flag set on any timeout.

Function
REQ-014 SHALL implement the FSM states IDLE, SERVE_I and SERVE_D; at most one requester is granted at any time.
REQ-015 In IDLE, when a D request (read OR write) is present and unmasked, SHALL move to SERVE_D; otherwise, when an I request is present and unmasked, SHALL move to SERVE_I; D request always wins when both are present.
REQ-016 On the grant edge SHALL latch address, write data and byte enables (I grant: PCForInstrMem, MemByteEnable=4'b1111, MemWriteData=0).
REQ-017 Mem*Enable SHALL be registered: a request sampled in cycle N drives the memory enable from cycle N+1, held constant until MemAck or timeout.
REQ-018 SERVE_I SHALL drive MemReadEnable=1 and MemWriteEnable=0; SERVE_D SHALL drive the latched read/write enables (both passed if both set).
REQ-019 When MemAck=1 in SERVE_x, SHALL forward it combinationally as the ack of the granted requester in the same cycle, route MemReadData to that requester's data output, and return to IDLE with the memory enables low on the next cycle.
REQ-020 SHALL mask the just-acked requester for exactly the one cycle after its ack (its enable is still high then); the other requester may be granted in that cycle.
REQ-021 A MemAck arriving in IDLE SHALL be ignored and produce no requester ack.
REQ-022 SHALL count cycles spent in SERVE_x; at count TIMEOUT_CYCLES without MemAck, SHALL pulse the granted requester's ack with data 32'h0, set BusError, and go to IDLE; MemAck and timeout in the same cycle is treated as a normal MemAck.
REQ-023 The counter SHALL clear on every grant, so it cannot wrap.
REQ-024 A requester dropping its enable before its ack SHALL NOT abort the memory access; the access completes, and its ack is still issued.

Reset
REQ-025 With RST=1 at a clock edge: state=IDLE, all Mem*Enable=0, MemAddress/MemWriteData=0, MemByteEnable=0, masks cleared, counter=0, BusError=0; InstrMemAck and DataMemAck SHALL be 0 while RST=1.
REQ-026 Reset during SERVE_x SHALL abandon the access with no ack, and the memory enables SHALL be low in the cycle after the reset edge.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum (IDLE, SERVE_I, SERVE_D) and the default TIMEOUT_CYCLES constant; counter width is $clog2(TIMEOUT_CYCLES+1).
REQ-028 No sub-module is needed; the FSM, latches and counter are in one module (target 120-250 lines).

Verification
REQ-029 I read alone: InstrMemReadEnable=1, PC=0x40, and the memory acks 3 cycles after its enable with 0x8C010004 -> MemReadEnable from cycle 1, InstrMemAck and Instruction=0x8C010004 in the MemAck cycle, and no second access in the mask cycle.
REQ-030 Simultaneous requests: I read 0x100 plus D write 0x2000/0xDEADBEEF with BE 4'b0011 in the same cycle -> D served first (MemWriteEnable=1, BE=0011), then I is granted in the cycle after DataMemAck.
REQ-031 Back-to-back: D ack, then I pending -> I grant lands in the mask cycle; D re-request in the mask cycle is ignored until the next cycle.
REQ-032 Timeout with TIMEOUT_CYCLES=8 and MemAck never asserted -> DataMemAck pulse with data 0 at count 8, BusError=1 and staying 1, arbiter accepts the next request.
REQ-033 RST=1 for one cycle mid-SERVE_I -> no InstrMemAck, MemReadEnable=0 on the next cycle, and a late MemAck in IDLE is ignored.
